jt1943_objscan: RTL and testbench

JT1943_OBJSCAN -- requirements
Module: jt1943_objscan

---
 rtl/jt1943_objscan.sv | 183 ++++++++++++++++++
 tb/tb_jt1943_objscan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_objscan.sv
// Object line scanner: a per-line search of object RAM fills one bank of a double-buffered
// slot line buffer, while the other bank is read out slot by slot for drawing.
module jt1943_objscan #(
  parameter int OBJMAX = 24,
  parameter int OBJN   = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen6,
  input  logic       HINIT,
  input  logic [7:0] VF,
  output logic [8:0] obj_AB,
  input  logic [7:0] obj_DB,
  output logic [4:0] objcnt,
  output logic [3:0] pxlcnt,
  output logic [7:0] objbuf_data,
  output logic       scan_busy,
  output logic       line_ovf,
  output logic       scan_late
);

  localparam int AW = $clog2(2 * OBJMAX);
  localparam logic [6:0] IDX_LAST = 7'(OBJN - 1);
  localparam logic [4:0] SLOT_LAST = 5'(OBJMAX - 1);
  localparam logic [4:0] SLOT_FULL = 5'(OBJMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READY,
    S_TEST,
    S_COPY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic        bank_sel;
  logic [1:0]  bank_ok;
  logic [4:0]  slot_cnt;
  logic [6:0]  idx;
  logic [2:0]  byte_cnt;
  logic [7:0]  vf_lat;
  logic        hit;

  logic [31:0]   lbuf [2*OBJMAX];
  logic          buf_we;
  logic [3:0]    buf_be;
  logic [7:0]    buf_wd;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [31:0]   rword;

  assign hit = (vf_lat >= obj_DB) && ((vf_lat - obj_DB) < 8'd16);
  assign scan_busy = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_nx = state;
    if (HINIT) begin
      state_nx = S_CLEAR;
    end else begin
      case (state)
        S_CLEAR: if (slot_cnt == SLOT_LAST) state_nx = S_READY;
        S_READY: state_nx = S_TEST;
        S_TEST:  state_nx = (hit && slot_cnt < SLOT_FULL) ? S_COPY : S_NEXT;
        S_COPY:  if (byte_cnt == 3'd4) state_nx = S_NEXT;
        S_NEXT:  state_nx = (idx == 7'd0) ? S_DONE : S_READY;
        default: state_nx = state;
      endcase
    end
  end

  // Write side always targets the bank not being drawn.
  always_comb begin
    buf_we    = 1'b0;
    buf_be    = 4'h0;
    buf_wd    = 8'h00;
    buf_waddr = AW'(slot_cnt) + (bank_sel ? AW'(0) : AW'(OBJMAX));
    if (cen6 && !HINIT) begin
      if (state == S_CLEAR) begin
        buf_we = 1'b1;
        buf_be = 4'hF;
        buf_wd = 8'hF0;
      end else if (state == S_COPY && byte_cnt != 3'd0) begin
        buf_we = 1'b1;
        buf_be = 4'h1 << (byte_cnt[1:0] - 2'd1);
        buf_wd = obj_DB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_be[b]) lbuf[buf_waddr][8*b +: 8] <= buf_wd;
      end
    end
  end

  assign buf_raddr = AW'(objcnt) + (bank_sel ? AW'(OBJMAX) : AW'(0));
  assign rword = lbuf[buf_raddr];

  // A bank that has not completed its CLEAR since reset/reuse reads as zero.
  always_comb begin
    objbuf_data = 8'h00;
    if (bank_ok[bank_sel] && pxlcnt < 4'd4) objbuf_data = rword[8*pxlcnt[1:0] +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bank_sel  <= 1'b0;
      bank_ok   <= 2'b00;
      obj_AB    <= 9'd0;
      objcnt    <= 5'd0;
      pxlcnt    <= 4'd0;
      slot_cnt  <= 5'd0;
      idx       <= 7'd0;
      byte_cnt  <= 3'd0;
      vf_lat    <= 8'd0;
      line_ovf  <= 1'b0;
      scan_late <= 1'b0;
    end else if (cen6) begin
      state <= state_nx;
      if (HINIT) begin
        bank_sel          <= ~bank_sel;
        bank_ok[bank_sel] <= 1'b0;
        slot_cnt          <= 5'd0;
        idx               <= IDX_LAST;
        byte_cnt          <= 3'd0;
        vf_lat            <= VF;
        line_ovf          <= 1'b0;
        objcnt            <= 5'd0;
        pxlcnt            <= 4'd0;
        if (state == S_DONE) scan_late <= 1'b0;
        else if (state != S_IDLE) scan_late <= 1'b1;
      end else begin
        if (!(objcnt == SLOT_LAST && pxlcnt == 4'd15)) begin
          pxlcnt <= pxlcnt + 4'd1;
          if (pxlcnt == 4'd15) objcnt <= objcnt + 5'd1;
        end
        case (state)
          S_CLEAR: begin
            if (slot_cnt == SLOT_LAST) begin
              slot_cnt           <= 5'd0;
              obj_AB             <= {idx, 2'd2};
              bank_ok[~bank_sel] <= 1'b1;
            end else begin
              slot_cnt <= slot_cnt + 5'd1;
            end
          end
          S_TEST: begin
            if (hit) begin
              if (slot_cnt < SLOT_FULL) begin
                obj_AB   <= {idx, 2'd0};
                byte_cnt <= 3'd0;
              end else begin
                line_ovf <= 1'b1;
              end
            end
          end
          S_COPY: begin
            if (byte_cnt == 3'd4) begin
              byte_cnt <= 3'd0;
              slot_cnt <= slot_cnt + 5'd1;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              obj_AB   <= {idx, byte_cnt[1:0] + 2'd1};
            end
          end
          S_NEXT: begin
            if (idx != 7'd0) begin
              idx    <= idx - 7'd1;
              obj_AB <= {idx - 7'd1, 2'd2};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt1943_objscan.sv
// Directed bench for jt1943_objscan: object RAM model, line sequences, draw readout checks.
module tb_jt1943_objscan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen6 = 1'b0;
  logic       hinit;
  logic [7:0] vf;
  logic [8:0] obj_ab;
  logic [7:0] obj_db = 8'h00;
  logic [4:0] objcnt;
  logic [3:0] pxlcnt;
  logic [7:0] objbuf_data;
  logic       scan_busy, line_ovf, scan_late;

  logic [7:0] ram [512];
  logic [1:0] cen_div = 2'd0;
  int n_checks = 0;
  int n_fail = 0;

  jt1943_objscan #(.OBJMAX(24), .OBJN(128)) dut (
    .clk(clk), .rst_n(rst_n), .cen6(cen6), .HINIT(hinit), .VF(vf),
    .obj_AB(obj_ab), .obj_DB(obj_db), .objcnt(objcnt), .pxlcnt(pxlcnt),
    .objbuf_data(objbuf_data), .scan_busy(scan_busy), .line_ovf(line_ovf),
    .scan_late(scan_late)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    cen_div = cen_div + 2'd1;
    cen6 = (cen_div == 2'd0);
  end

  always @(posedge clk) if (cen6) obj_db <= ram[obj_ab];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!cen6) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic hinit_pulse(input logic [7:0] v);
    vf = v;
    hinit = 1'b1;
    wait_tick();
    hinit = 1'b0;
  endtask

  function automatic logic [7:0] exp_byte(input int s, input int p, input int n, input logic [7:0] y);
    logic [7:0] id;
    if (s >= n) return 8'hF0;
    id = 8'(127 - s);
    case (p)
      0: return id;
      1: return id ^ 8'h5A;
      2: return y;
      default: return ~id;
    endcase
  endfunction

  task automatic draw_check(input string nm, input int n, input logic [7:0] y);
    for (int k = 0; k < 384; k++) begin
      check_eq($sformatf("%s objcnt k=%0d", nm, k), 32'(objcnt), 32'(k / 16));
      check_eq($sformatf("%s pxlcnt k=%0d", nm, k), 32'(pxlcnt), 32'(k % 16));
      if (k % 16 < 4)
        check_eq($sformatf("%s data slot=%0d byte=%0d", nm, k / 16, k % 16),
                 32'(objbuf_data), 32'(exp_byte(k / 16, k % 16, n, y)));
      wait_tick();
    end
    check_eq({nm, " hold objcnt"}, 32'(objcnt), 32'd23);
    check_eq({nm, " hold pxlcnt"}, 32'(pxlcnt), 32'd15);
  endtask

  task automatic set_y(input int lo, input logic [7:0] y);
    for (int i = lo; i < 128; i++) ram[4*i+2] = y;
  endtask

  task automatic check_reset_outputs(input string nm);
    check_eq({nm, " obj_AB"}, 32'(obj_ab), 32'd0);
    check_eq({nm, " objcnt"}, 32'(objcnt), 32'd0);
    check_eq({nm, " pxlcnt"}, 32'(pxlcnt), 32'd0);
    check_eq({nm, " objbuf_data"}, 32'(objbuf_data), 32'd0);
    check_eq({nm, " scan_busy"}, 32'(scan_busy), 32'd0);
    check_eq({nm, " line_ovf"}, 32'(line_ovf), 32'd0);
    check_eq({nm, " scan_late"}, 32'(scan_late), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    hinit = 1'b0;
    vf = 8'h00;
    for (int i = 0; i < 128; i++) begin
      ram[4*i]   = 8'(i);
      ram[4*i+1] = 8'(i) ^ 8'h5A;
      ram[4*i+2] = 8'hF0;
      ram[4*i+3] = ~8'(i);
    end
    ram[127*4+2] = 8'h40;
    repeat (6) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single hit, VF=45 against y=40
    hinit_pulse(8'h45);
    check_eq("L1 busy in clear", 32'(scan_busy), 32'd1);
    idle(24);
    check_eq("L1 first ready addr", 32'(obj_ab), 32'h1FE);
    idle(576);
    check_eq("L1 scan done", 32'(scan_busy), 32'd0);
    check_eq("L1 ovf", 32'(line_ovf), 32'd0);

    hinit_pulse(8'h4F);
    check_eq("L2 late", 32'(scan_late), 32'd0);
    draw_check("L2", 1, 8'h40);
    idle(215);
    check_eq("L2 ovf", 32'(line_ovf), 32'd0);

    hinit_pulse(8'h50);
    draw_check("L3", 1, 8'h40);
    idle(215);

    hinit_pulse(8'h3F);
    draw_check("L4", 0, 8'h40);
    idle(215);
    set_y(98, 8'h40);

    hinit_pulse(8'h45);
    draw_check("L5", 0, 8'h40);
    idle(215);
    check_eq("L5 ovf", 32'(line_ovf), 32'd1);
    check_eq("L5 late", 32'(scan_late), 32'd0);
    set_y(0, 8'h40);

    // All objects hit, next HINIT 300 ticks later
    hinit_pulse(8'h45);
    check_eq("L6 late", 32'(scan_late), 32'd0);
    idle(299);
    hinit_pulse(8'h45);
    check_eq("L7 late", 32'(scan_late), 32'd1);
    check_eq("L7 ovf cleared", 32'(line_ovf), 32'd0);
    draw_check("L7", 24, 8'h40);
    idle(215);
    check_eq("L7 ovf", 32'(line_ovf), 32'd1);

    // Abort after exactly four completed copies
    hinit_pulse(8'h45);
    check_eq("L8 late", 32'(scan_late), 32'd0);
    idle(57);
    hinit_pulse(8'h45);
    check_eq("L9 late", 32'(scan_late), 32'd1);
    draw_check("L9", 4, 8'h40);
    idle(215);

    hinit_pulse(8'h45);
    check_eq("L10 late", 32'(scan_late), 32'd0);
    draw_check("L10", 24, 8'h40);
    idle(215);

    // Reset pulse in the middle of a COPY
    hinit_pulse(8'h45);
    idle(28);
    check_eq("L11 busy before reset", 32'(scan_busy), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    check_eq("after reset idle", 32'(scan_busy), 32'd0);

    hinit_pulse(8'h45);
    idle(600);
    check_eq("L12 done", 32'(scan_busy), 32'd0);
    hinit_pulse(8'h45);
    check_eq("L13 late", 32'(scan_late), 32'd0);
    draw_check("L13", 24, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
